// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the 5-stage core and its hazard controller.
// master = pipeline side (drives decode/EX fields, consumes controls),
// slave  = hazard controller.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    // Decode stage
    logic [4:0]       RA1_2;
    logic [4:0]       RA2_2;
    logic [4:0]       WA_2;
    logic             RegWrite2;
    logic             MemRead2;
    logic             use_rs1_2;
    logic             use_rs2_2;
    // Execute stage
    logic [4:0]       RA1_3;
    logic [4:0]       RA2_3;
    logic             ALUsrc1_3;
    logic             ALUsrc2_3;
    logic             MemWrite3;
    logic             jump;
    // Pipeline controls
    logic             stall_if;
    logic             flush_id;
    logic             bubble_ex;
    // Forwarding selects
    logic             forward1_ex;
    logic             z4_z5_logical_1;
    logic             forward2_ex;
    logic             z4_z5_logical_2;
    logic             forward_sw_ex;
    logic             z4_z5_sw_ex;
    // Event counters and FSM state for observation
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       fsm_state;

    modport master (
        output RA1_2, RA2_2, WA_2, RegWrite2, MemRead2, use_rs1_2, use_rs2_2,
        output RA1_3, RA2_3, ALUsrc1_3, ALUsrc2_3, MemWrite3, jump,
        input  stall_if, flush_id, bubble_ex,
        input  forward1_ex, z4_z5_logical_1, forward2_ex, z4_z5_logical_2,
        input  forward_sw_ex, z4_z5_sw_ex,
        input  stall_count, flush_count, fsm_state
    );

    modport slave (
        input  RA1_2, RA2_2, WA_2, RegWrite2, MemRead2, use_rs1_2, use_rs2_2,
        input  RA1_3, RA2_3, ALUsrc1_3, ALUsrc2_3, MemWrite3, jump,
        output stall_if, flush_id, bubble_ex,
        output forward1_ex, z4_z5_logical_1, forward2_ex, z4_z5_logical_2,
        output forward_sw_ex, z4_z5_sw_ex,
        output stall_count, flush_count, fsm_state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage core: shadows destination-register
// state of EX/MEM/WB, drives EX forwarding selects, sequences load-use
// stalls and jump flushes, and counts stall/flush events (saturating).
module hazard_control_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input logic clk,
    input logic rst,
    hazard_control_unit_if.slave hif
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    // Bubbles still owed after the first stall cycle spent in RUN.
    localparam logic [1:0] RELOAD = 2'(LOAD_STALL_CYCLES - 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
        logic       regwrite;
        logic       memread;
    } slot_t;

    slot_t            ex_q, mem_q, wb_q;
    logic [1:0]       state_q, state_d;
    logic [1:0]       left_q, left_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic hz;
    logic stall_if, flush_id, bubble_ex;
    logic stall_inc, flush_inc;
    logic [1:0] fwd1, fwd2, fwd_sw;

    // A slot supplies src when it writes a nonzero register equal to src.
    // In MEM a load has no data yet, so block_load excludes it there.
    function automatic logic supplies(slot_t s, logic [4:0] src, logic block_load);
        return s.valid & s.regwrite & ~(block_load & s.memread) &
               (s.wa != 5'd0) & (s.wa == src);
    endfunction

    // {forward, select}: MEM (Z4, select 0) beats WB (Z5, select 1).
    function automatic logic [1:0] fwd_sel(slot_t m, slot_t w, logic [4:0] src, logic en);
        if (!en)                         return 2'b00;
        else if (supplies(m, src, 1'b1)) return 2'b10;
        else if (supplies(w, src, 1'b0)) return 2'b11;
        else                             return 2'b00;
    endfunction

    // Load in EX whose destination is read by the instruction in decode.
    always_comb begin
        hz = ex_q.valid & ex_q.memread & (ex_q.wa != 5'd0) &
             ((hif.use_rs1_2 & (hif.RA1_2 == ex_q.wa)) |
              (hif.use_rs2_2 & (hif.RA2_2 == ex_q.wa)));
    end

    // Stall/flush sequencing; a jump outranks a coincident load-use hazard.
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        stall_if  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (hif.jump) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = FLUSH;
                end else if (hz) begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                    stall_inc = 1'b1;
                    left_d    = RELOAD;
                    if (LOAD_STALL_CYCLES > 1) state_d = STALL;
                end
            end
            STALL: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
                stall_inc = 1'b1;
                left_d    = left_q - 2'd1;
                if (left_d == 2'd0) state_d = RUN;
            end
            FLUSH: begin
                // Gives the redirected fetch one cycle to land in IF/ID.
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Forwarding selects for the instruction currently in EX.
    always_comb begin
        fwd1   = fwd_sel(mem_q, wb_q, hif.RA1_3, hif.ALUsrc1_3);
        fwd2   = fwd_sel(mem_q, wb_q, hif.RA2_3, hif.ALUsrc2_3);
        fwd_sw = fwd_sel(mem_q, wb_q, hif.RA2_3, hif.MemWrite3);
    end

    // Shadow pipeline advances every cycle; a bubble enters EX as invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= bubble_ex ? '0 : {1'b1, hif.WA_2, hif.RegWrite2, hif.MemRead2};
        end
    end

    // FSM state and remaining-bubble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            left_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hif.stall_if        = stall_if;
    assign hif.flush_id        = flush_id;
    assign hif.bubble_ex       = bubble_ex;
    assign hif.forward1_ex     = fwd1[1];
    assign hif.z4_z5_logical_1 = fwd1[0];
    assign hif.forward2_ex     = fwd2[1];
    assign hif.z4_z5_logical_2 = fwd2[0];
    assign hif.forward_sw_ex   = fwd_sw[1];
    assign hif.z4_z5_sw_ex     = fwd_sw[0];
    assign hif.stall_count     = stall_cnt_q;
    assign hif.flush_count     = flush_cnt_q;
    assign hif.fsm_state       = state_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1-cycle stall / 16-bit
// counters, and 3-cycle stall / 3-bit counters) share one stimulus stream
// and are each compared against a behavioural model every cycle.
module tb_hazard_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(16)) if_a ();
    hazard_control_unit_if #(.CNT_W(3))  if_b ();

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .hif(if_a));
    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(3))  dut_b (.clk(clk), .rst(rst), .hif(if_b));

    typedef struct packed {
        logic [4:0] ra1_2, ra2_2, wa_2;
        logic       rw2, mr2, u1, u2;
        logic [4:0] ra1_3, ra2_3;
        logic       as1, as2, mw3, jump;
    } stim_t;

    stim_t cur = '0;
    assign {if_a.RA1_2, if_a.RA2_2, if_a.WA_2, if_a.RegWrite2, if_a.MemRead2, if_a.use_rs1_2,
            if_a.use_rs2_2, if_a.RA1_3, if_a.RA2_3, if_a.ALUsrc1_3, if_a.ALUsrc2_3,
            if_a.MemWrite3, if_a.jump} = cur;
    assign {if_b.RA1_2, if_b.RA2_2, if_b.WA_2, if_b.RegWrite2, if_b.MemRead2, if_b.use_rs1_2,
            if_b.use_rs2_2, if_b.RA1_3, if_b.RA2_3, if_b.ALUsrc1_3, if_b.ALUsrc2_3,
            if_b.MemWrite3, if_b.jump} = cur;

    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Index 0 = instance a, 1 = instance b. Pipeline is a 3-entry array
    // (0 = EX, 1 = MEM, 2 = WB); sequencing is "bubbles still owed" plus
    // a pending-flush flag.
    typedef struct { bit v; bit [4:0] wa; bit rw; bit mr; } slot_t;
    slot_t m_sh[2][3];
    int    m_left[2];
    bit    m_flush[2];
    int    m_stalls[2];
    int    m_flushes[2];
    int    m_lsc[2]  = '{1, 3};
    int    m_cmax[2] = '{65535, 7};

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) m_sh[k][j] = '{1'b0, 5'd0, 1'b0, 1'b0};
            m_left[k] = 0; m_flush[k] = 1'b0; m_stalls[k] = 0; m_flushes[k] = 0;
        end
    endtask

    function automatic bit m_hz(int k, stim_t s);
        slot_t e = m_sh[k][0];
        return e.v && e.mr && e.wa != 0 &&
               ((s.u1 && s.ra1_2 == e.wa) || (s.u2 && s.ra2_2 == e.wa));
    endfunction

    function automatic logic [1:0] m_fwd(int k, logic [4:0] src, logic en);
        slot_t m = m_sh[k][1];
        slot_t w = m_sh[k][2];
        if (!en || src == 0) return 2'b00;
        if (m.v && m.rw && !m.mr && m.wa == src) return 2'b10;
        if (w.v && w.rw && w.wa == src) return 2'b11;
        return 2'b00;
    endfunction

    // {stall_if, flush_id, bubble_ex, fwd1/sel1, fwd2/sel2, fwd_sw/sel_sw}
    function automatic logic [8:0] m_ctl(int k, stim_t s);
        logic [2:0] c = 3'b000;
        if (m_flush[k])        c = 3'b000;
        else if (m_left[k] > 0) c = 3'b101;
        else if (s.jump)        c = 3'b011;
        else if (m_hz(k, s))    c = 3'b101;
        return {c, m_fwd(k, s.ra1_3, s.as1), m_fwd(k, s.ra2_3, s.as2), m_fwd(k, s.ra2_3, s.mw3)};
    endfunction

    task automatic m_step(int k, stim_t s);
        bit hz  = m_hz(k, s);
        bit bub = 1'b0;
        if (m_flush[k]) begin
            m_flush[k] = 1'b0;
        end else if (m_left[k] > 0) begin
            m_left[k]--; bub = 1'b1;
            if (m_stalls[k] < m_cmax[k]) m_stalls[k]++;
        end else if (s.jump) begin
            m_flush[k] = 1'b1; bub = 1'b1;
            if (m_flushes[k] < m_cmax[k]) m_flushes[k]++;
        end else if (hz) begin
            bub = 1'b1; m_left[k] = m_lsc[k] - 1;
            if (m_stalls[k] < m_cmax[k]) m_stalls[k]++;
        end
        m_sh[k][2] = m_sh[k][1];
        m_sh[k][1] = m_sh[k][0];
        if (bub) m_sh[k][0] = '{1'b0, 5'd0, 1'b0, 1'b0};
        else     m_sh[k][0] = '{1'b1, s.wa_2, s.rw2, s.mr2};
    endtask

    // ---------------- DUT observation ----------------
    function automatic logic [8:0] dut_ctl(int k);
        if (k == 0)
            return {if_a.stall_if, if_a.flush_id, if_a.bubble_ex, if_a.forward1_ex, if_a.z4_z5_logical_1,
                    if_a.forward2_ex, if_a.z4_z5_logical_2, if_a.forward_sw_ex, if_a.z4_z5_sw_ex};
        return {if_b.stall_if, if_b.flush_id, if_b.bubble_ex, if_b.forward1_ex, if_b.z4_z5_logical_1,
                if_b.forward2_ex, if_b.z4_z5_logical_2, if_b.forward_sw_ex, if_b.z4_z5_sw_ex};
    endfunction

    function automatic logic [31:0] dut_stalls(int k);
        return (k == 0) ? 32'(if_a.stall_count) : 32'(if_b.stall_count);
    endfunction

    function automatic logic [31:0] dut_flushes(int k);
        return (k == 0) ? 32'(if_a.flush_count) : 32'(if_b.flush_count);
    endfunction

    // ---------------- driver tasks ----------------
    // Drive one cycle's inputs after the falling edge, compare, advance model.
    task automatic apply(stim_t s);
        @(negedge clk);
        cur = s;
        #1;
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "ctl_a" : "ctl_b", 32'(dut_ctl(k)), 32'(m_ctl(k, s)));
            check(k == 0 ? "stall_cnt_a" : "stall_cnt_b", dut_stalls(k), m_stalls[k]);
            check(k == 0 ? "flush_cnt_a" : "flush_cnt_b", dut_flushes(k), m_flushes[k]);
        end
        for (int k = 0; k < 2; k++) m_step(k, s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cur = '0;
        rst = 1'b1;
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "rst_ctl_a" : "rst_ctl_b", 32'(dut_ctl(k)), 32'd0);
            check(k == 0 ? "rst_stall_a" : "rst_stall_b", dut_stalls(k), 32'd0);
            check(k == 0 ? "rst_flush_a" : "rst_flush_b", dut_flushes(k), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic stim_t dec(logic [4:0] wa, logic [4:0] ra1, logic [4:0] ra2,
                                  logic rw, logic mr, logic u1, logic u2);
        stim_t s = '0;
        s.wa_2 = wa; s.ra1_2 = ra1; s.ra2_2 = ra2;
        s.rw2 = rw; s.mr2 = mr; s.u1 = u1; s.u2 = u2;
        return s;
    endfunction

    function automatic stim_t ex(stim_t s, logic [4:0] ra1, logic [4:0] ra2,
                                 logic as1, logic as2, logic mw);
        s.ra1_3 = ra1; s.ra2_3 = ra2; s.as1 = as1; s.as2 = as2; s.mw3 = mw;
        return s;
    endfunction

    function automatic stim_t rnd_stim(bit allow_load);
        stim_t s;
        s.ra1_2 = 5'($urandom_range(0, 3));
        s.ra2_2 = 5'($urandom_range(0, 3));
        s.wa_2  = 5'($urandom_range(0, 3));
        s.rw2   = ($urandom_range(0, 3) != 0);
        s.mr2   = allow_load && ($urandom_range(0, 2) == 0);
        s.u1    = 1'($urandom_range(0, 1));
        s.u2    = 1'($urandom_range(0, 1));
        s.ra1_3 = 5'($urandom_range(0, 3));
        s.ra2_3 = 5'($urandom_range(0, 3));
        s.as1   = 1'($urandom_range(0, 1));
        s.as2   = 1'($urandom_range(0, 1));
        s.mw3   = 1'($urandom_range(0, 1));
        s.jump  = allow_load && ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    localparam stim_t NOP = '0;

    initial begin
        // ADD r3 ; SUB r4,r3,r5 -> MEM forward (Z4)
        do_reset();
        apply(dec(3, 1, 2, 1, 0, 1, 1));
        apply(ex(dec(4, 3, 5, 1, 0, 1, 1), 1, 2, 1, 1, 0));
        apply(ex(NOP, 3, 5, 1, 1, 0));
        check("add_sub_mem_fwd1", {if_a.forward1_ex, if_a.z4_z5_logical_1}, 2'b10);

        // ADD r3 ; independent ; SUB -> WB forward (Z5)
        do_reset();
        apply(dec(3, 1, 2, 1, 0, 1, 1));
        apply(ex(dec(9, 1, 1, 1, 0, 1, 1), 1, 2, 1, 1, 0));
        apply(ex(dec(4, 3, 5, 1, 0, 1, 1), 1, 1, 1, 1, 0));
        apply(ex(NOP, 3, 5, 1, 1, 0));
        check("add_x_sub_wb_fwd1", {if_a.forward1_ex, if_a.z4_z5_logical_1}, 2'b11);

        // LOAD r2 ; ADD r6,r2,r2 -> one stall, then both operands from Z5
        do_reset();
        apply(dec(2, 1, 0, 1, 1, 1, 0));
        apply(ex(dec(6, 2, 2, 1, 0, 1, 1), 1, 0, 1, 0, 0));
        check("lu_stall", {if_a.stall_if, if_a.bubble_ex}, 2'b11);
        apply(dec(6, 2, 2, 1, 0, 1, 1));
        check("lu_stall_end", if_a.stall_if, 1'b0);
        check("lu_stall_cnt", 32'(if_a.stall_count), 32'd1);
        apply(ex(NOP, 2, 2, 1, 1, 0));
        check("lu_fwd_both_z5", {if_a.forward1_ex, if_a.z4_z5_logical_1,
                                 if_a.forward2_ex, if_a.z4_z5_logical_2}, 4'b1111);

        // r0 destination never forwards or stalls; ALUsrc2_3=0 blocks forward2
        do_reset();
        apply(dec(0, 1, 1, 1, 1, 1, 1));
        apply(ex(dec(5, 0, 0, 1, 0, 1, 1), 1, 1, 1, 1, 0));
        check("r0_no_stall", if_a.stall_if, 1'b0);
        apply(ex(dec(8, 1, 1, 1, 0, 1, 1), 0, 0, 1, 1, 0));
        check("r0_no_fwd", {if_a.forward1_ex, if_a.forward2_ex}, 2'b00);
        apply(ex(NOP, 1, 1, 1, 1, 0));
        apply(ex(NOP, 0, 8, 1, 0, 0));
        check("alusrc2_off", if_a.forward2_ex, 1'b0);

        // jump together with load-use: flush wins, then one idle FLUSH cycle
        do_reset();
        apply(dec(2, 1, 0, 1, 1, 1, 0));
        begin
            stim_t s = ex(dec(6, 2, 2, 1, 0, 1, 1), 1, 0, 1, 0, 0);
            s.jump = 1'b1;
            apply(s);
            check("jmp_hz_ctl", {if_a.stall_if, if_a.flush_id, if_a.bubble_ex}, 3'b011);
        end
        apply(dec(6, 2, 2, 1, 0, 1, 1));
        check("flush_idle", {if_a.stall_if, if_a.flush_id, if_a.bubble_ex}, 3'b000);
        check("jmp_flush_cnt", 32'(if_a.flush_count), 32'd1);
        check("jmp_stall_cnt", 32'(if_a.stall_count), 32'd0);

        // SW r7 after ADD r7 -> store data from Z4; MEM beats WB
        do_reset();
        apply(dec(7, 1, 2, 1, 0, 1, 1));
        apply(ex(dec(0, 1, 7, 0, 0, 1, 1), 1, 2, 1, 1, 0));
        apply(ex(NOP, 1, 7, 1, 0, 1));
        check("sw_fwd_z4", {if_a.forward_sw_ex, if_a.z4_z5_sw_ex}, 2'b10);
        apply(dec(7, 1, 2, 1, 0, 1, 1));
        apply(ex(dec(7, 3, 4, 1, 0, 1, 1), 1, 2, 1, 1, 0));
        apply(ex(NOP, 3, 4, 1, 1, 0));
        apply(ex(NOP, 7, 0, 1, 0, 0));
        check("mem_over_wb", {if_a.forward1_ex, if_a.z4_z5_logical_1}, 2'b10);

        // 3-cycle stall instance: reset during the 2nd stall cycle
        do_reset();
        apply(dec(2, 1, 0, 1, 1, 1, 0));
        apply(ex(dec(6, 2, 2, 1, 0, 1, 1), 1, 0, 1, 0, 0));
        apply(dec(6, 2, 2, 1, 0, 1, 1));
        check("b_stall2", {if_b.stall_if, if_b.bubble_ex}, 2'b11);
        #1 rst = 1'b1;
        #1;
        m_reset();
        check("b_async_rst_ctl", 32'(dut_ctl(1)), 32'd0);
        check("b_async_rst_cnt", 32'(if_b.stall_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) apply(rnd_stim(1'b0));
        check("b_no_stall_after", 32'(if_b.stall_count), 32'd0);

        // Random traffic; long enough to saturate the 3-bit counters
        do_reset();
        for (int i = 0; i < 600; i++) apply(rnd_stim(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage core.
- Keeps a shadow copy of destination-register state for the EX, MEM and WB stages.
- Drives the forwarding selects consumed by the execution stage (forward1_ex, forward2_ex, z4_z5_logical_1/2, forward_sw_ex, z4_z5_sw_ex).
- Sequences load-use stalls and jump/branch flushes through a small FSM, and keeps saturating stall/flush event counters.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3)
CNT_W, 16, width of the stall/flush event counters

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
RA1_2  input  5  decode-stage source register 1
RA2_2  input  5  decode-stage source register 2
WA_2  input  5  decode-stage destination register
RegWrite2  input  1  decode instruction writes a register
MemRead2  input  1  decode instruction is a load
use_rs1_2  input  1  decode instruction reads RA1_2 as a register operand
use_rs2_2  input  1  decode instruction reads RA2_2, either as an ALU operand or as store data
RA1_3  input  5  EX-stage source register 1
RA2_3  input  5  EX-stage source register 2
ALUsrc1_3  input  1  EX operand 1 is register X3 (0 = PC)
ALUsrc2_3  input  1  EX operand 2 is register Y3 (0 = imm)
MemWrite3  input  1  EX instruction is a store; store data comes from RA2_3
jump  input  1  EX-stage redirect (Jump3 | cond3)
stall_if  output  1  hold PC and the IF/ID register
flush_id  output  1  load NOP into IF/ID
bubble_ex  output  1  load NOP into ID/EX
forward1_ex  output  1  RS1 takes the forwarded value
z4_z5_logical_1  output  1  RS1 forward source: 0 = Z4, 1 = Z5
forward2_ex  output  1  RS2 takes the forwarded value
z4_z5_logical_2  output  1  RS2 forward source: 0 = Z4, 1 = Z5
forward_sw_ex  output  1  store data takes the forwarded value
z4_z5_sw_ex  output  1  store data forward source: 0 = Z4, 1 = Z5
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  jump flushes, saturating

Behaviour:
- Clock and reset
  - One clock, clk. rst is asynchronous, active-high.
  - On reset: all shadow slots invalid, FSM in RUN, counters 0.
  - Therefore all control and forward outputs are 0 during and immediately after reset.
- Shadow pipeline
  - Three slots: EXs, MEMs, WBs. Each holds {valid, wa, regwrite, memread}.
  - Every edge: WBs <= MEMs; MEMs <= EXs.
  - EXs <= decode fields with valid = 1, unless bubble_ex is 1, in which case EXs <= invalid.
  - Register 0 is hardwired zero. A slot whose wa is 0 never matches any source.
- Forwarding (combinational from slots and EX inputs)
  - MEM match: MEMs.valid & MEMs.regwrite & ~MEMs.memread & wa == src.
  - WB match: WBs.valid & WBs.regwrite & wa == src.
  - MEM match has priority over WB match; it yields forward = 1 with select 0 (Z4).
  - WB match alone yields forward = 1 with select 1 (Z5). No match yields forward = 0 with select 0.
  - Operand 1 uses src = RA1_3, and applies only when ALUsrc1_3 = 1.
  - Operand 2 uses src = RA2_3, and applies only when ALUsrc2_3 = 1.
  - Store data uses src = RA2_3, and applies only when MemWrite3 = 1.
  - Jump has no effect on forwarding.
- Load-use detect
  - hz = EXs.valid & EXs.memread & EXs.wa != 0 & ((use_rs1_2 & RA1_2 == EXs.wa) | (use_rs2_2 & RA2_2 == EXs.wa)).
- FSM states: RUN, STALL, FLUSH.
- RUN
  - jump = 1: flush_id = 1, bubble_ex = 1, stall_if = 0; go to FLUSH; flush_count increments.
  - else hz = 1: stall_if = 1, bubble_ex = 1; load the down-counter with LOAD_STALL_CYCLES-1; stall_count increments. Go to STALL if LOAD_STALL_CYCLES > 1, else stay in RUN.
  - else all controls are 0.
- STALL
  - stall_if = 1, bubble_ex = 1; stall_count increments; the counter decrements.
  - Return to RUN when the counter reaches 0 in this cycle.
  - A jump cannot occur here, because EX holds a bubble.
- FLUSH
  - Exactly one cycle, all controls 0; return to RUN.
  - This lets the redirected fetch reach IF/ID before hazards are evaluated again.
- Simultaneous events
  - jump and hz in the same cycle: jump wins, because the stalled decode instruction is younger and is discarded. Only flush_count increments.
- Counters saturate at all-ones.
- Reset asserted mid-stall or mid-flush returns the block to RUN with all slots invalid in the same cycle, asynchronously.

Test Plan:
- ADD r3 followed by SUB r4, r3, r5: at SUB in EX, forward1_ex = 1, z4_z5_logical_1 = 0. With one independent instruction between them: forward1_ex = 1, z4_z5_logical_1 = 1.
- LOAD r2 followed by ADD r6, r2, r2: exactly one cycle with stall_if = 1 and bubble_ex = 1; stall_count = 1. ADD then sees forward1_ex = 1, forward2_ex = 1, both selects = 1 (Z5).
- r0 as destination then source: no forward and no stall. ALUsrc2_3 = 0 with RA2_3 matching: forward2_ex = 0.
- jump = 1 together with a load-use hz: flush_id = 1 and bubble_ex = 1 for one cycle, then one FLUSH cycle with all controls 0. stall_if stays 0; flush_count = 1, stall_count = 0.
- Store SW r7 one instruction after ADD r7: forward_sw_ex = 1, z4_z5_sw_ex = 0. MEM and WB both writing r7: Z4 is selected (priority).
- LOAD_STALL_CYCLES = 3, then rst pulsed during the 2nd stall cycle: all outputs go to 0 immediately. After release, a non-hazard sequence shows no stall and stall_count = 0.
